filler_scheduler: RTL

- Arbitrates fill jobs from up to NUM_REQ stations onto one shared filler FSM.
- Issues a single-cycle startfill to the filler and waits for its lleno_flag completion strobe.
- Reports per-station completion, a running fill count, and a sticky timeout error.
- Sits between the station request logic and the filler controller.

---
 rtl/filler_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/filler_scheduler.sv
// Round-robin scheduler granting one station at a time onto a shared filler FSM.
// Optional macro FILLER_SCHED_PRIORITY_EN switches arbitration to fixed lowest-index priority.
module filler_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic               filler_lleno,
  input  logic               clr_err,
  output logic               startfill,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done_pulse,
  output logic [CNT_W-1:0]   fill_count,
  output logic               timeout_err,
  output logic [1:0]         sched_state
);

  // state    | meaning
  // IDLE     | waiting for an enabled request, arbitrates
  // START    | one-cycle startfill to the filler
  // WAIT     | waiting for lleno_flag or timeout
  // COOLDOWN | grant dropped, done_pulse on success, filler returns to idle
  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_START    = 2'b01;
  localparam logic [1:0] S_WAIT     = 2'b10;
  localparam logic [1:0] S_COOLDOWN = 2'b11;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [TMR_W-1:0] timer;
  logic             job_ok;

  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             win_vld;

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
`ifdef FILLER_SCHED_PRIORITY_EN
    // Scanning downward leaves the lowest asserted index as the winner.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = IDX_W'(i);
        win_vld = 1'b1;
      end
    end
`else
    // Search starts just past the last served station so every station gets a turn.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      timer       <= '0;
      fill_count  <= '0;
      timeout_err <= 1'b0;
      job_ok      <= 1'b0;
    end else begin
      if (clr_err) timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && win_vld) begin
            idx   <= win_idx;
            state <= S_START;
          end
        end
        S_START: begin
          timer  <= '0;
          job_ok <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (filler_lleno) begin
            state  <= S_COOLDOWN;
            job_ok <= 1'b1;
`ifndef FILLER_SCHED_PRIORITY_EN
            rr_ptr <= idx;
`endif
            if (fill_count != '1) fill_count <= fill_count + 1'b1;
          end else if (timer == TMR_LAST) begin
            // A timeout set overrides a clr_err arriving in the same cycle.
            timeout_err <= 1'b1;
            state       <= S_COOLDOWN;
            job_ok      <= 1'b0;
`ifndef FILLER_SCHED_PRIORITY_EN
            rr_ptr      <= idx;
`endif
          end
        end
        S_COOLDOWN: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  assign startfill   = (state == S_START);
  assign grant       = (state == S_START || state == S_WAIT) ? (ONE << idx) : '0;
  assign done_pulse  = (state == S_COOLDOWN && job_ok) ? (ONE << idx) : '0;
  assign sched_state = state;

endmodule
